tick_scheduler: RTL
===================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of independent divided-clock channels, range 2..8.
REQ-002 Parameter CW, default 16: divisor/counter width in bits.
REQ-003 clock  in  1  system clock; all state SHALL be updated on its posedge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_valid  in  1  configuration request valid.
REQ-006 cfg_ready  out  1  configuration request can be accepted.
REQ-007 cfg_ch  in  clog2(NCH)  target channel index.
REQ-008 cfg_div  in  CW  requested divisor.
REQ-009 cfg_en  in  1  requested channel enable.
REQ-010 cfg_err  out  1  one-cycle pulse: accepted request rejected.
REQ-011 tick  out  NCH  per-channel one-cycle pulse, once per divided period.
REQ-012 div_clk  out  NCH  per-channel divided square wave.
REQ-013 pending  out  NCH  per-channel flag: update accepted, not yet applied.

Function
REQ-014 Per channel, registered state SHALL be: en, div_act (CW), count (CW), pend_en, pend_div (CW), pending.
REQ-015 Accept = cfg_valid && cfg_ready; cfg_ready SHALL equal !pending[cfg_ch] (combinational on cfg_ch).
REQ-016 cfg_valid with cfg_ch >= NCH SHALL be accepted and rejected: cfg_err pulses, no state change.
REQ-017 Request with cfg_en=1 and cfg_div=0 SHALL be accepted and rejected: cfg_err pulses next cycle, no state change.
REQ-018 cfg_err SHALL be registered: high exactly in the cycle after a rejected accept.
REQ-019 Boundary of a channel = en && count == div_act-1.
REQ-020 Enabled channel, no boundary: count SHALL increment by 1 each cycle.
REQ-021 At a boundary with no update to apply: count SHALL wrap to 0, div_act unchanged.
REQ-022 Accept to a disabled channel: en<=cfg_en, div_act<=cfg_div, count<=0 on the next edge; pending stays 0.
REQ-023 Accept to an enabled channel not at boundary: pend_en/pend_div<=request, pending<=1.
REQ-024 At a boundary with pending=1: en<=pend_en, div_act<=pend_div, count<=0, pending<=0.
REQ-025 Accept to an enabled channel in its boundary cycle: request SHALL be applied at that edge directly (bypass); pending stays 0.
REQ-026 Disable (cfg_en=0) SHALL follow the same rules; disabled channel: count held 0, tick=0, div_clk=0.
REQ-027 tick[i] = en && count == div_act-1; div_clk[i] = en && count < ceil(div_act/2).
REQ-028 tick and div_clk SHALL be decoded from registered state only, with no combinational path from cfg_* inputs.
REQ-029 div_act=1: tick constantly 1, div_clk constantly 1 while enabled.
REQ-030 Even div_act: div_clk 50% duty; odd: high ceil(div/2), low floor(div/2) cycles.
REQ-031 No update SHALL take effect mid-period on an enabled channel: no runt/shortened period on div_clk.
REQ-032 Channels SHALL be fully independent; simultaneous boundaries on several channels SHALL all be honoured the same cycle.
REQ-033 Counter arithmetic SHALL be CW-bit unsigned; div_act=2^CW-1 SHALL work without overflow.

Reset
REQ-034 Under rst: all en, count, div_act, pending, pend_* SHALL be 0; cfg_err=0; tick=0, div_clk=0.
REQ-035 rst SHALL override any same-cycle accept; the request SHALL be dropped.
REQ-036 rst mid-period SHALL drop pending updates; cfg_ready=1 on the first cycle after rst deasserts.

Verification
REQ-037 Reset, then ch0 {en=1, div=4} -> from next cycle, count 0,1,2,3 repeating; tick high every 4th cycle; div_clk 1100 pattern.
REQ-038 ch1 {en=1, div=5}, then {div=3} at count=1 -> pending[1]=1 and cfg_ready=0 for ch1; switches to period 3 only after count=4; div_clk 11100 then 110.
REQ-039 Request div=0 en=1 on ch2 -> cfg_err one-cycle pulse; ch2 state unchanged.
REQ-040 ch0 at div=4: update {div=2} presented exactly when count=3 -> applied at that edge; next cycle count=0, period 2, pending[0] never set.
REQ-041 ch3 enabled div=7, disable at count=2 -> runs to count=6, then tick/div_clk stay 0; re-enable div=1 -> tick and div_clk constantly 1.
REQ-042 rst asserted while pending[1]=1 together with a new accept -> all outputs 0, pending=0, request lost, cfg_ready=1 after release.

Source files
------------

// File: rtl/tick_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_scheduler_if : channel configuration request/accept handshake        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface tick_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_en;
  logic           cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_scheduler : NCH independent clock dividers, glitch-free reconfig     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tick_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  wire logic           clock,
  input  wire logic           rst,
  tick_scheduler_if.slave     cfg,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      div_clk,
  output logic [NCH-1:0]      pending
);

  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSLOT = 1 << CHW;

  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] pend_en_q, pend_en_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [CW-1:0]  div_q  [NCH];
  logic [CW-1:0]  div_d  [NCH];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  pdiv_q [NCH];
  logic [CW-1:0]  pdiv_d [NCH];
  logic           err_q, err_d;

  logic [NSLOT-1:0] pend_pad;
  logic             ch_ok;
  logic             accept;
  logic             bad_req;
  logic             apply_ok;
  logic [NCH-1:0]   sel;
  logic [NCH-1:0]   bnd;

  // Out-of-range channel indices see a zero pending slot, so they are always ready.
  assign pend_pad      = NSLOT'(pending_q);
  assign cfg.cfg_ready = !pend_pad[cfg.cfg_ch];
  assign ch_ok         = ({1'b0, cfg.cfg_ch} < (CHW+1)'(NCH));
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign bad_req       = !ch_ok || (cfg.cfg_en && (cfg.cfg_div == '0));
  assign apply_ok      = accept && !bad_req;
  assign cfg.cfg_err   = err_q;
  assign pending       = pending_q;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW:0] half;
      assign sel[i]     = apply_ok && (cfg.cfg_ch == CHW'(i));
      assign bnd[i]     = en_q[i] && (cnt_q[i] == div_q[i] - CW'(1));
      assign half       = ({1'b0, div_q[i]} + (CW+1)'(1)) >> 1;
      assign tick[i]    = bnd[i];
      assign div_clk[i] = en_q[i] && ({1'b0, cnt_q[i]} < half);
    end
  endgenerate

  always_comb begin
    en_d      = en_q;
    pend_en_d = pend_en_q;
    pending_d = pending_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    pdiv_d    = pdiv_q;
    err_d     = accept && bad_req;
    for (int i = 0; i < NCH; i++) begin
      if (!en_q[i]) begin
        cnt_d[i]     = '0;
        pending_d[i] = 1'b0;
        if (sel[i]) begin
          en_d[i]  = cfg.cfg_en;
          div_d[i] = cfg.cfg_div;
        end
      end else if (bnd[i]) begin
        // Period end: a same-cycle request wins over the (necessarily empty) pending slot.
        cnt_d[i]     = '0;
        pending_d[i] = 1'b0;
        if (sel[i]) begin
          en_d[i]  = cfg.cfg_en;
          div_d[i] = cfg.cfg_div;
        end else if (pending_q[i]) begin
          en_d[i]  = pend_en_q[i];
          div_d[i] = pdiv_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
        if (sel[i]) begin
          pend_en_d[i] = cfg.cfg_en;
          pdiv_d[i]    = cfg.cfg_div;
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      en_q      <= '0;
      pend_en_q <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i]  <= '0;
        cnt_q[i]  <= '0;
        pdiv_q[i] <= '0;
      end
    end else begin
      en_q      <= en_d;
      pend_en_q <= pend_en_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pdiv_q    <= pdiv_d;
    end
  end

endmodule
`default_nettype wire
